rr_ring_arbiter: RTL

- Round-robin arbiter that shares one resource between N requesters.
- Priority rotates through a one-hot ring pointer, advanced like a ring counter but only when a grant is issued.
- Sits between requesting blocks and the shared datapath; issues a registered one-hot grant.
- Grant is held until the requester releases it, or until the hold limit forces preemption.

---
 rtl/arb_pkg.sv | 37 +++
 rtl/rr_ring_ptr.sv | 23 ++
 rtl/rr_ring_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
// Helpers work on a fixed MAX_N-bit container so any N up to MAX_N can use them.
package arb_pkg;

  localparam int DEFAULT_N        = 4;
  localparam int DEFAULT_MAX_HOLD = 8;
  localparam int MAX_N            = 32;
  localparam int MAX_IDX_W        = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index of the set bit of a one-hot vector; 0 for an all-zero vector.
  function automatic int onehot_to_bin(input logic [MAX_N-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Rotate the low n bits of v left by one; bits at n and above come back zero.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] r;
    int               j;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      j = (i + 1 == n) ? 0 : i + 1;
      if (i < n) r[j[MAX_IDX_W-1:0]] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_ring_ptr.sv
// One-hot priority ring register: resets to bit 0 and, on load,
// moves to the position just above the winner (with wrap).
module rr_ring_ptr
  import arb_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] winner,
  output logic [N-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= N'(1);
    end else if (load) begin
      ptr <= N'(rotl1(MAX_N'(winner), N));
    end
  end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter: registered one-hot grant, rotating one-hot priority
// pointer, and an optional per-tenure hold limit that forces preemption.
module rr_ring_arbiter
  import arb_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic [N-1:0]    ptr
);

  // Handshake: a requester raises req and keeps it high for as long as it
  // wants the resource; grant/grant_id are meaningful only while grant_valid
  // is high, and dropping req releases the grant at the next edge.

  localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  arb_state_e       state;
  logic [CNT_W-1:0] count;
  logic [N-1:0]     cand;
  logic [N-1:0]     win;
  logic [ID_W-1:0]  win_id;
  logic             keep;
  logic             load;

  always_comb begin
    int  ptr_idx;
    int  idx;
    logic found;
    ptr_idx = onehot_to_bin(MAX_N'(ptr));
    keep    = (state == BUSY) && (|(req & grant)) &&
              ((MAX_HOLD == 0) || (count < CNT_W'(MAX_HOLD)));
    // The current holder never competes in its own re-arbitration; this is
    // what turns a hog into a one-cycle idle gap when nobody else is asking.
    cand    = (state == BUSY) ? (req & ~grant) : req;
    win     = '0;
    win_id  = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_idx + k;
      if (idx >= N) idx = idx - N;
      if (!found && cand[idx[ID_W-1:0]]) begin
        found                 = 1'b1;
        win                   = '0;
        win[idx[ID_W-1:0]]    = 1'b1;
        win_id                = idx[ID_W-1:0];
      end
    end
    load = !keep && found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      count       <= '0;
    end else if (keep) begin
      if (MAX_HOLD != 0) count <= count + CNT_W'(1);
    end else if (load) begin
      state       <= BUSY;
      grant       <= win;
      grant_valid <= 1'b1;
      grant_id    <= win_id;
      count       <= CNT_W'(1);
    end else begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      count       <= '0;
    end
  end

  rr_ring_ptr #(.N(N)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .winner (win),
    .ptr    (ptr)
  );

endmodule
